// File: rtl/gfx_rect_fill.sv
// Rectangle fill engine: normalises and clips one rectangle command, then streams
// every covered pixel in row-major order on a valid/ready pixel interface.
module gfx_rect_fill #(
    parameter int FB_WIDTH   = 640,
    parameter int FB_HEIGHT  = 480,
    parameter int PIXEL_BITS = 12,
    localparam int FB_X_BITS = $clog2(FB_WIDTH),
    localparam int FB_Y_BITS = $clog2(FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [FB_X_BITS-1:0]  cmd_x0,
    input  logic [FB_X_BITS-1:0]  cmd_x1,
    input  logic [FB_Y_BITS-1:0]  cmd_y0,
    input  logic [FB_Y_BITS-1:0]  cmd_y1,
    input  logic [PIXEL_BITS-1:0] cmd_color,
    output logic                  pvalid,
    input  logic                  pready,
    output logic [FB_X_BITS-1:0]  x,
    output logic [FB_Y_BITS-1:0]  y,
    output logic [PIXEL_BITS-1:0] color,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    localparam logic [FB_X_BITS-1:0] X_LAST = FB_X_BITS'(FB_WIDTH - 1);
    localparam logic [FB_Y_BITS-1:0] Y_LAST = FB_Y_BITS'(FB_HEIGHT - 1);

    state_t                state_q;
    logic [FB_X_BITS-1:0]  cx0_q, cx1_q;
    logic [FB_Y_BITS-1:0]  cy0_q, cy1_q;
    logic [PIXEL_BITS-1:0] ccolor_q;
    logic [FB_X_BITS-1:0]  xmin_q, xmax_q, x_q;
    logic [FB_Y_BITS-1:0]  ymax_q, y_q;
    logic [PIXEL_BITS-1:0] color_q;
    logic                  pvalid_q;
    logic                  done_q;

    logic [FB_X_BITS-1:0]  xmin_d, xmax_d;
    logic [FB_Y_BITS-1:0]  ymin_d, ymax_d;
    logic                  off_screen_d;
    logic                  last_beat;

    // Corner normalisation and clipping, consumed only in SETUP.
    always_comb begin
        xmin_d       = (cx0_q < cx1_q) ? cx0_q : cx1_q;
        xmax_d       = (cx0_q < cx1_q) ? cx1_q : cx0_q;
        ymin_d       = (cy0_q < cy1_q) ? cy0_q : cy1_q;
        ymax_d       = (cy0_q < cy1_q) ? cy1_q : cy0_q;
        off_screen_d = (xmin_d > X_LAST) || (ymin_d > Y_LAST);
        if (xmax_d > X_LAST) xmax_d = X_LAST;
        if (ymax_d > Y_LAST) ymax_d = Y_LAST;
    end

    assign last_beat = pvalid_q && (x_q == xmax_q) && (y_q == ymax_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cx0_q    <= '0;
            cx1_q    <= '0;
            cy0_q    <= '0;
            cy1_q    <= '0;
            ccolor_q <= '0;
            xmin_q   <= '0;
            xmax_q   <= '0;
            ymax_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            color_q  <= '0;
            pvalid_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        cx0_q    <= cmd_x0;
                        cx1_q    <= cmd_x1;
                        cy0_q    <= cmd_y0;
                        cy1_q    <= cmd_y1;
                        ccolor_q <= cmd_color;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    if (off_screen_d) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        xmin_q   <= xmin_d;
                        xmax_q   <= xmax_d;
                        ymax_q   <= ymax_d;
                        x_q      <= xmin_d;
                        y_q      <= ymin_d;
                        color_q  <= ccolor_q;
                        pvalid_q <= 1'b1;
                        state_q  <= DRAW;
                    end
                end
                DRAW: begin
                    if (pready) begin
                        // Counters hold on the final beat so they never pass xmax/ymax.
                        if (last_beat) begin
                            pvalid_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                        end else if (x_q != xmax_q) begin
                            x_q <= x_q + 1'b1;
                        end else begin
                            x_q <= xmin_q;
                            y_q <= y_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);
    assign pvalid    = pvalid_q;
    assign x         = x_q;
    assign y         = y_q;
    assign color     = color_q;
    assign last      = last_beat;
    assign done      = done_q;

endmodule

// File: tb/tb_gfx_rect_fill.sv
// Bench for gfx_rect_fill: a queue of expected beats built from each accepted command,
// checked every cycle, plus literal expectations for the directed rectangles.
module tb_gfx_rect_fill;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0, cmd_x1;
    logic [8:0]  cmd_y0, cmd_y1;
    logic [11:0] cmd_color;
    logic        pvalid;
    logic        pready;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [11:0] color;
    logic        last;
    logic        busy;
    logic        done;

    gfx_rect_fill dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color),
        .pvalid(pvalid), .pready(pready),
        .x(x), .y(y), .color(color), .last(last),
        .busy(busy), .done(done)
    );

    localparam int W   = 640;
    localparam int H   = 480;
    localparam int BIG = 1 << 30;

    typedef struct {int bx; int by; int bc;} beat_t;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    stall = 0;
    beat_t q[$];
    int    acc_cyc  = 0;
    int    done_cyc = -1;
    int    first_cyc = 0;
    bit    rst_prev = 0;
    int    st_beats, st_acc, st_first, st_lastc, st_done;
    int    st_fx, st_fy, st_lx, st_ly;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        pready = 1;
        forever begin
            @(posedge clk);
            #1;
            pready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Model + compare, sampled on the falling edge.
    always @(negedge clk) begin
        bit ep, eb;
        int xl, xh, yl, yh;
        if (reset) begin
            chk("ready_in_reset", cmd_ready, 0);
            if (rst_prev) begin
                chk("rst_pvalid", pvalid, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_last", last, 0);
                chk("rst_x", x, 0);
                chk("rst_y", y, 0);
                chk("rst_color", color, 0);
            end
            q.delete();
            done_cyc = -1;
            acc_cyc  = cyc;
            rst_prev = 1;
        end else begin
            rst_prev = 0;
            ep = (q.size() > 0) && (cyc >= first_cyc);
            eb = (cyc > acc_cyc) && (cyc < done_cyc);
            chk("pvalid", pvalid, ep);
            chk("cmd_ready", cmd_ready, !eb);
            chk("busy", busy, eb);
            chk("done", done, cyc == done_cyc);
            if (pvalid && ep) begin
                chk("x", x, q[0].bx);
                chk("y", y, q[0].by);
                chk("color", color, q[0].bc);
                chk("last", last, q.size() == 1);
            end
            if (pvalid && pready) begin
                if (st_beats == 0) begin
                    st_fx = x; st_fy = y; st_first = cyc;
                end
                st_lx = x; st_ly = y; st_lastc = cyc;
                st_beats++;
            end
            if (done) st_done = cyc;
            if (ep && pready) begin
                void'(q.pop_front());
                if (q.size() == 0) done_cyc = cyc + 1;
            end
            if (!eb && cmd_valid) begin
                xl = (cmd_x0 < cmd_x1) ? cmd_x0 : cmd_x1;
                xh = (cmd_x0 < cmd_x1) ? cmd_x1 : cmd_x0;
                yl = (cmd_y0 < cmd_y1) ? cmd_y0 : cmd_y1;
                yh = (cmd_y0 < cmd_y1) ? cmd_y1 : cmd_y0;
                if (xh > W - 1) xh = W - 1;
                if (yh > H - 1) yh = H - 1;
                acc_cyc   = cyc;
                first_cyc = cyc + 2;
                st_beats  = 0;
                st_acc    = cyc;
                st_done   = -1;
                if (xl >= W || yl >= H) begin
                    done_cyc = cyc + 2;
                end else begin
                    done_cyc = BIG;
                    for (int j = yl; j <= yh; j++)
                        for (int i = xl; i <= xh; i++)
                            q.push_back('{i, j, int'(cmd_color)});
                end
            end
        end
    end

    task automatic start_cmd(input int x0, x1, y0, y1, c, output bit got);
        @(posedge clk);
        #1;
        cmd_x0 = 10'(x0); cmd_x1 = 10'(x1);
        cmd_y0 = 9'(y0);  cmd_y1 = 9'(y1);
        cmd_color = 12'(c);
        cmd_valid = 1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1;
            @(posedge clk);
            #1;
        end
        cmd_valid = 0;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL accept_timeout: got no cmd_ready expected 1");
        end
    endtask

    // nb < 0 skips the literal pins (random commands).
    task automatic send(input int x0, x1, y0, y1, c, nb, fx, fy, lx, ly);
        bit got, seen;
        start_cmd(x0, x1, y0, y1, c, got);
        seen = 0;
        for (int i = 0; i < 5000 && !seen && got; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: got no done expected done pulse");
        end
        @(posedge clk);
        #1;
        if (nb >= 0) begin
            chk("beat_count", st_beats, nb);
            if (nb == 0) begin
                chk("offscreen_done_lat", st_done - st_acc, 2);
            end else begin
                chk("first_lat", st_first - st_acc, 2);
                chk("done_after_last", st_done - st_lastc, 1);
                chk("consecutive", st_lastc - st_first + 1, stall ? st_lastc - st_first + 1 : nb);
                chk("first_x", st_fx, fx);
                chk("first_y", st_fy, fy);
                chk("last_x", st_lx, lx);
                chk("last_y", st_ly, ly);
            end
        end
    endtask

    initial begin
        bit got, seen;
        int x0, y0, x1, y1;
        reset = 1; cmd_valid = 0;
        cmd_x0 = 0; cmd_x1 = 0; cmd_y0 = 0; cmd_y1 = 0; cmd_color = 0;
        st_beats = 0; st_acc = 0; st_first = 0; st_lastc = 0; st_done = -1;
        st_fx = 0; st_fy = 0; st_lx = 0; st_ly = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;

        send(2, 4, 3, 4, 'hF00, 6, 2, 3, 4, 4);
        send(4, 2, 4, 3, 'hF00, 6, 2, 3, 4, 4);
        send(639, 639, 479, 479, 'h123, 1, 639, 479, 639, 479);
        send(630, 1000, 470, 500, 'h0F0, 100, 630, 470, 639, 479);
        send(640, 700, 0, 10, 'h00F, 0, 0, 0, 0, 0);

        stall = 1;
        send(10, 13, 20, 23, 'h0AB, 16, 10, 20, 13, 23);
        stall = 0;

        // Reset during the 5th beat of a 10x10 rectangle.
        start_cmd(0, 9, 0, 9, 'h555, got);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (st_beats == 4) seen = 1;
        end
        chk("reached_beat5", seen, 1);
        @(posedge clk);
        #1;
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        send(5, 8, 7, 9, 'hABC, 12, 5, 7, 8, 9);

        for (int n = 0; n < 20; n++) begin
            stall = ($urandom_range(0, 1) == 1);
            x0 = $urandom_range(0, 700);
            y0 = $urandom_range(0, 500);
            x1 = x0 + $urandom_range(0, 15);
            y1 = y0 + $urandom_range(0, 15);
            if (x1 > 1023) x1 = 1023;
            if (y1 > 511) y1 = 511;
            if ($urandom_range(0, 1) == 1) send(x1, x0, y0, y1, $urandom_range(0, 4095), -1, 0, 0, 0, 0);
            else send(x0, x1, y1, y0, $urandom_range(0, 4095), -1, 0, 0, 0, 0);
        end
        stall = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
